lane_host_sequencer: RTL and testbench

//  Host-side initiator for the lane-detection accelerator's register-style AXI port.

---
 rtl/lane_host_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_lane_host_sequencer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lane_host_sequencer.sv
// lane_host_sequencer: host-side initiator for the lane-detection accelerator.
// Soft reset, 24->32 bit pixel packing, OVALID poll, output map readback.
module lane_host_sequencer #(
  parameter int IN_WIDTH       = 512,
  parameter int IN_HEIGHT      = 256,
  parameter int OUT_WIDTH      = 64,
  parameter int OUT_HEIGHT     = 32,
  parameter int AXI_ADDR_WIDTH = 20,
  parameter int OFFSET_INPUT   = 0,
  parameter int OFFSET_OUTPUT  = 393216,
  parameter int OFFSET_OVALID  = 395264,
  parameter int OFFSET_RESET   = 395272,
  parameter int RESET_WAIT     = 16,
  parameter int POLL_TIMEOUT   = 2**24
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [23:0]               s_pix_data,
  input  logic                      s_pix_valid,
  output logic                      s_pix_ready,
  output logic [31:0]               m_res_data,
  output logic                      m_res_valid,
  input  logic                      m_res_ready,
  output logic                      done,
  output logic                      timeout_err,
  output logic                      seq_busy,
  output logic [31:0]               axi_wr_data,
  output logic [AXI_ADDR_WIDTH-1:0] axi_wr_addr,
  output logic                      axi_wr_en,
  output logic [3:0]                axi_wr_strobe,
  output logic [AXI_ADDR_WIDTH-1:0] axi_rd_addr,
  output logic                      axi_rd_en,
  input  logic [31:0]               axi_rd_data
);
  localparam int AW     = AXI_ADDR_WIDTH;
  localparam int NWORDS = IN_WIDTH * IN_HEIGHT * 3 / 4;
  localparam int NRES   = OUT_WIDTH * OUT_HEIGHT / 4;
  localparam int WW     = $clog2(NWORDS + 1);
  localparam int RW     = $clog2(NRES + 1);
  localparam int PW     = $clog2(POLL_TIMEOUT + 1);
  localparam int TW     = $clog2(RESET_WAIT + 1);

  localparam logic [AW-1:0] A_IN  = AW'(OFFSET_INPUT);
  localparam logic [AW-1:0] A_OUT = AW'(OFFSET_OUTPUT);
  localparam logic [AW-1:0] A_OV  = AW'(OFFSET_OVALID);
  localparam logic [AW-1:0] A_RST = AW'(OFFSET_RESET);

  typedef enum logic [3:0] {
    IDLE, SRST, SRST_WAIT, LOAD, POLL_REQ,
    POLL_CHK, RD_REQ, RD_CAP, RD_OUT, DONE
  } state_t;

  state_t state, state_n;

  logic [WW-1:0] wcnt;
  logic [RW-1:0] rcnt;
  logic [PW-1:0] pcnt;
  logic [TW-1:0] tcnt;
  logic [1:0]    cnt;
  logic [23:0]   res;
  logic          set_to;
  logic [AW-1:0] rd_a;

  assign rd_a = A_OUT + AW'({rcnt, 2'b00});

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n       = state;
    s_pix_ready   = 1'b0;
    m_res_valid   = 1'b0;
    done          = 1'b0;
    seq_busy      = (state != IDLE);
    axi_wr_en     = 1'b0;
    axi_wr_data   = '0;
    axi_wr_addr   = '0;
    axi_wr_strobe = '0;
    axi_rd_en     = 1'b0;
    axi_rd_addr   = '0;
    set_to        = 1'b0;
    unique case (state)
      IDLE: if (start) state_n = SRST;
      SRST: begin
        axi_wr_en     = 1'b1;
        axi_wr_addr   = A_RST;
        axi_wr_data   = 32'd1;
        axi_wr_strobe = 4'b0001;
        state_n       = SRST_WAIT;
      end
      SRST_WAIT: if (tcnt == TW'(RESET_WAIT - 1)) state_n = LOAD;
      LOAD: begin
        s_pix_ready = 1'b1;
        if (s_pix_valid) begin
          unique case (cnt)
            2'd0: ;
            2'd3: begin
              axi_wr_en   = 1'b1;
              axi_wr_data = {s_pix_data[7:0], res};
            end
            2'd2: begin
              axi_wr_en   = 1'b1;
              axi_wr_data = {s_pix_data[15:0], res[15:0]};
            end
            2'd1: begin
              axi_wr_en   = 1'b1;
              axi_wr_data = {s_pix_data, res[7:0]};
            end
          endcase
          if (axi_wr_en) begin
            axi_wr_addr   = A_IN + AW'({wcnt, 2'b00});
            axi_wr_strobe = 4'hF;
            if (wcnt == WW'(NWORDS - 1)) state_n = POLL_REQ;
          end
        end
      end
      POLL_REQ: begin
        axi_rd_en   = 1'b1;
        axi_rd_addr = A_OV;
        state_n     = POLL_CHK;
      end
      POLL_CHK: begin
        axi_rd_addr = A_OV;
        if (axi_rd_data[0]) begin
          state_n = RD_REQ;
        end else if (pcnt == PW'(POLL_TIMEOUT - 1)) begin
          set_to  = 1'b1;
          state_n = DONE;
        end else begin
          state_n = POLL_REQ;
        end
      end
      RD_REQ: begin
        axi_rd_en   = 1'b1;
        axi_rd_addr = rd_a;
        state_n     = RD_CAP;
      end
      RD_CAP: begin
        axi_rd_addr = rd_a;
        state_n     = RD_OUT;
      end
      RD_OUT: begin
        axi_rd_addr = rd_a;
        m_res_valid = 1'b1;
        if (m_res_ready)
          state_n = (rcnt == RW'(NRES - 1)) ? DONE : RD_REQ;
      end
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Packer residue holds the bytes of the current pixel not yet written.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wcnt        <= '0;
      rcnt        <= '0;
      pcnt        <= '0;
      tcnt        <= '0;
      cnt         <= '0;
      res         <= '0;
      m_res_data  <= '0;
      timeout_err <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (start) timeout_err <= 1'b0;
        SRST: begin
          wcnt <= '0;
          rcnt <= '0;
          pcnt <= '0;
          tcnt <= '0;
          cnt  <= '0;
          res  <= '0;
        end
        SRST_WAIT: tcnt <= tcnt + 1'b1;
        LOAD: begin
          if (s_pix_valid) begin
            unique case (cnt)
              2'd0: begin res <= s_pix_data; cnt <= 2'd3; end
              2'd3: begin res <= {8'h0, s_pix_data[23:8]}; cnt <= 2'd2; end
              2'd2: begin res <= {16'h0, s_pix_data[23:16]}; cnt <= 2'd1; end
              2'd1: cnt <= 2'd0;
            endcase
          end
          if (axi_wr_en) wcnt <= wcnt + 1'b1;
        end
        POLL_CHK: begin
          if (!axi_rd_data[0]) pcnt <= pcnt + 1'b1;
          if (set_to) timeout_err <= 1'b1;
        end
        RD_CAP: m_res_data <= axi_rd_data;
        RD_OUT: if (m_res_ready) rcnt <= rcnt + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lane_host_sequencer.sv
// tb_lane_host_sequencer: scoreboard bench for lane_host_sequencer.
// Accelerator model answers OVALID polls and output-map reads.
module tb_lane_host_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [23:0] s_pix_data = '0;
  logic        s_pix_valid = 1'b0;
  logic        s_pix_ready;
  logic [31:0] m_res_data;
  logic        m_res_valid;
  logic        m_res_ready = 1'b0;
  logic        done;
  logic        timeout_err;
  logic        seq_busy;
  logic [31:0] axi_wr_data;
  logic [19:0] axi_wr_addr;
  logic        axi_wr_en;
  logic [3:0]  axi_wr_strobe;
  logic [19:0] axi_rd_addr;
  logic        axi_rd_en;
  logic [31:0] axi_rd_data = '0;

  lane_host_sequencer #(
    .IN_WIDTH(8), .IN_HEIGHT(4), .OUT_WIDTH(8), .OUT_HEIGHT(4),
    .AXI_ADDR_WIDTH(20), .OFFSET_INPUT(0), .OFFSET_OUTPUT(96),
    .OFFSET_OVALID(128), .OFFSET_RESET(136),
    .RESET_WAIT(16), .POLL_TIMEOUT(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .s_pix_data(s_pix_data), .s_pix_valid(s_pix_valid),
    .s_pix_ready(s_pix_ready),
    .m_res_data(m_res_data), .m_res_valid(m_res_valid),
    .m_res_ready(m_res_ready),
    .done(done), .timeout_err(timeout_err), .seq_busy(seq_busy),
    .axi_wr_data(axi_wr_data), .axi_wr_addr(axi_wr_addr),
    .axi_wr_en(axi_wr_en), .axi_wr_strobe(axi_wr_strobe),
    .axi_rd_addr(axi_rd_addr), .axi_rd_en(axi_rd_en),
    .axi_rd_data(axi_rd_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [19:0] a;
    logic [31:0] d;
    logic [3:0]  s;
  } wr_t;

  wr_t         wr_q[$];
  logic [19:0] rd_q[$];
  logic [31:0] res_q[$];

  int checks = 0;
  int errors = 0;
  int in_wr = 0;
  int poll_n = 0;
  int ovalid_at = 0;
  bit mon_en = 1'b1;

  logic [31:0] outmem [8];
  logic [19:0] rd_off;
  assign rd_off = axi_rd_addr - 20'd96;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got unexpected event expected none", name);
  endtask

  // Accelerator model: both OVALID and output RAM answer one cycle after rd_en.
  always @(posedge clk) begin
    if (axi_rd_en) begin
      if (axi_rd_addr == 20'd128) begin
        axi_rd_data <= (poll_n >= ovalid_at) ? 32'd1 : 32'd0;
        poll_n <= poll_n + 1;
      end else begin
        axi_rd_data <= outmem[rd_off[4:2]];
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (axi_wr_en) begin
        if (wr_q.size() == 0) fail("wr_unexpected");
        else chk("wr", {axi_wr_addr, axi_wr_data, axi_wr_strobe},
                 wr_q.pop_front());
        if (axi_wr_addr != 20'd136) begin
          in_wr++;
          chk("wr_needs_pixel", {s_pix_valid, s_pix_ready}, 2'b11);
        end
        chk("wr_rd_overlap", axi_rd_en, 1'b0);
      end
      if (axi_rd_en) begin
        if (rd_q.size() == 0) fail("rd_unexpected");
        else chk("rd_addr", axi_rd_addr, rd_q.pop_front());
      end
      if (m_res_valid && m_res_ready) begin
        if (res_q.size() == 0) fail("res_unexpected");
        else chk("res_data", m_res_data, res_q.pop_front());
      end
    end
  end

  function automatic logic [23:0] pix(input int i);
    return {8'(3*i+3), 8'(3*i+2), 8'(3*i+1)};
  endfunction

  task automatic push_frame(input int nz);
    bit rd = (nz < 4);
    wr_q.push_back('{20'd136, 32'd1, 4'b0001});
    for (int w = 0; w < 24; w++)
      wr_q.push_back('{20'(4*w),
        {8'(4*w+4), 8'(4*w+3), 8'(4*w+2), 8'(4*w+1)}, 4'hF});
    for (int p = 0; p < (rd ? nz + 1 : 4); p++) rd_q.push_back(20'd128);
    if (rd)
      for (int j = 0; j < 8; j++) begin
        rd_q.push_back(20'(96 + 4*j));
        res_q.push_back(outmem[j]);
      end
  endtask

  task automatic send_pix(input logic [23:0] p, input bit gaps);
    bit ok = 1'b0;
    int g = gaps ? int'($urandom_range(0, 2)) : 0;
    repeat (g) begin
      s_pix_valid = 1'b0;
      @(posedge clk); #1;
    end
    s_pix_valid = 1'b1;
    s_pix_data  = p;
    for (int k = 0; k < 64 && !ok; k++) begin
      @(negedge clk);
      ok = s_pix_ready;
      @(posedge clk); #1;
    end
    s_pix_valid = 1'b0;
    if (!ok) chk("pix_accept_timeout", 0, 1);
  endtask

  task automatic start_frame();
    int n = 0;
    bit quiet = 1'b1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk("start_clears_timeout", timeout_err, 1'b0);
    chk("srst_write", {axi_wr_en, axi_wr_addr}, {1'b1, 20'd136});
    for (int k = 0; k < 40; k++) begin
      if (k > 0) @(negedge clk);
      if (s_pix_ready) break;
      if (k > 0 && (axi_wr_en || axi_rd_en)) quiet = 1'b0;
      n++;
    end
    chk("srst_len", n, 17);
    chk("srst_quiet", quiet, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic run_frame(input int nz, input bit gaps, input bit hold);
    bit got = 1'b0;
    in_wr = 0;
    ovalid_at = poll_n + nz;
    push_frame(nz);
    start_frame();
    for (int i = 0; i < 32; i++) send_pix(pix(i), gaps);
    if (hold) begin
      for (int k = 0; k < 200 && !got; k++) begin
        @(negedge clk);
        got = m_res_valid;
      end
      chk("first_res_valid", got, 1'b1);
      for (int k = 0; k < 5; k++) begin
        if (k > 0) @(negedge clk);
        chk("hold_data", m_res_data, 32'hDEADBEEF);
        chk("hold_no_read", {axi_rd_en, m_res_valid}, 2'b01);
        start = (k == 1);
      end
      start = 1'b0;
    end
    m_res_ready = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 300 && !got; k++) begin
      @(negedge clk);
      got = done;
    end
    chk("done_pulse", got, 1'b1);
    chk("timeout_err", timeout_err, nz >= 4);
    @(negedge clk);
    chk("done_one_cycle", {done, seq_busy}, 2'b00);
    m_res_ready = 1'b0;
    chk("input_words", in_wr, 24);
    chk("queues_empty", wr_q.size() + rd_q.size() + res_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    outmem[0] = 32'hDEADBEEF;
    for (int j = 1; j < 8; j++) outmem[j] = 32'h1000_0000 + 32'h0101_0101 * j;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset_outputs", {s_pix_ready, m_res_data, m_res_valid, done,
        timeout_err, seq_busy, axi_wr_en, axi_rd_en}, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    run_frame(3, 1'b1, 1'b1);
    run_frame(1000, 1'b0, 1'b0);

    mon_en = 1'b0;
    start_frame();
    for (int i = 0; i < 5; i++) send_pix(pix(i), 1'b0);
    chk("mid_load_busy", {seq_busy, s_pix_ready}, 2'b11);
    rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("mid_reset_ctl", {s_pix_ready, m_res_valid, done, timeout_err,
        seq_busy, axi_wr_en, axi_rd_en, axi_wr_strobe}, 0);
    chk("mid_reset_bus", {m_res_data, axi_wr_data, axi_wr_addr,
        axi_rd_addr}, 0);
    wr_q.delete();
    rd_q.delete();
    res_q.delete();
    mon_en = 1'b1;

    run_frame(0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
